// File: rtl/hex_pkg.sv
// Shared types, segment constants and the hex glyph table for hex_display_ctrl.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package hex_pkg;

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} hex_state_t;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [6:0] SEG_MINUS  = 7'h3F;
   localparam logic [4:0] CODE_BLANK = 5'h10;
   localparam logic [4:0] CODE_MINUS = 5'h11;

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] seg;
      unique case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational digit-code to active-low 7-segment decoder.
// The top bit of the code selects special codes: minus, otherwise blank.
module seg_decode
   import hex_pkg::*;
#(
   parameter int unsigned VALUE_W = 5
) (
   input  logic [VALUE_W-1:0] code_i,
   output logic [6:0]         seg_o
);

   logic [VALUE_W-2:0] low;

   always_comb begin
      low = code_i[VALUE_W-2:0];
      if (code_i[VALUE_W-1]) begin
         seg_o = (low == (VALUE_W-1)'(1)) ? SEG_MINUS : SEG_BLANK;
      end else begin
         seg_o = hex_glyph(code_i[3:0]);
      end
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// Sequenced driver for a bank of active-low 7-segment displays: captures digit codes,
// decodes them MSB-first through one shared decoder and commits all digits at once.
// Optional feature: define HEX_BLINK_EN to add blink_mask and the BLINK_DIV blink counter.
module hex_display_ctrl
   import hex_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned VALUE_W    = 5
`ifdef HEX_BLINK_EN
   ,
   parameter int unsigned BLINK_DIV  = 25_000_000
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [VALUE_W-1:0] value [NUM_DIGITS-1:0],
   input  logic               blank_lz,
   input  logic               load,
   output logic               ready,
   output logic               done,
`ifdef HEX_BLINK_EN
   input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
   output logic [6:0]         Hex_value [NUM_DIGITS-1:0]
);

   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   hex_state_t         state_q, state_d;
   logic [IdxW-1:0]    idx_q, idx_d;
   logic               lz_q, lz_d;
   logic               done_q, done_d;
   logic [VALUE_W-1:0] shadow_q [NUM_DIGITS-1:0];
   logic [VALUE_W-1:0] shadow_d [NUM_DIGITS-1:0];
   logic [6:0]         work_q   [NUM_DIGITS-1:0];
   logic [6:0]         work_d   [NUM_DIGITS-1:0];
   logic [6:0]         disp_q   [NUM_DIGITS-1:0];
   logic [6:0]         disp_d   [NUM_DIGITS-1:0];

   logic [VALUE_W-1:0] cur_code;
   logic [6:0]         dec_seg;
   logic               lz_blank;

   assign cur_code = shadow_q[idx_q];

   seg_decode #(
      .VALUE_W (VALUE_W)
   ) u_seg_decode (
      .code_i (cur_code),
      .seg_o  (dec_seg)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      lz_d     = lz_q;
      done_d   = 1'b0;
      shadow_d = shadow_q;
      work_d   = work_q;
      disp_d   = disp_q;
      // Digit 0 is never blanked so an all-zero value still shows "0".
      lz_blank = lz_q && (cur_code == '0) && (idx_q != '0);

      unique case (state_q)
         IDLE: begin
            if (load) begin
               shadow_d = value;
               lz_d     = blank_lz;
               idx_d    = IdxW'(NUM_DIGITS - 1);
               state_d  = CONVERT;
            end
         end
         CONVERT: begin
            work_d[idx_q] = lz_blank ? SEG_BLANK : dec_seg;
            if (cur_code != '0) begin
               lz_d = 1'b0;
            end
            if (idx_q == '0) begin
               state_d = COMMIT;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         COMMIT: begin
            disp_d  = work_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         lz_q    <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            shadow_q[i] <= '0;
            work_q[i]   <= SEG_BLANK;
            disp_q[i]   <= SEG_BLANK;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         lz_q     <= lz_d;
         done_q   <= done_d;
         shadow_q <= shadow_d;
         work_q   <= work_d;
         disp_q   <= disp_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign done  = done_q;

`ifdef HEX_BLINK_EN
   localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CntW-1:0] blink_cnt_q;
   logic            blink_phase_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == CntW'(BLINK_DIV - 1)) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= ~blink_phase_q;
      end else begin
         blink_cnt_q   <= blink_cnt_q + 1'b1;
      end
   end

   // Masking only affects what is driven; the committed digits stay intact.
   always_comb begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         Hex_value[i] = (blink_phase_q && blink_mask[i]) ? SEG_BLANK : disp_q[i];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         Hex_value[i] = disp_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl: latency, blanking, special codes,
// dropped loads, back-to-back updates and reset abort (plus blinking when HEX_BLINK_EN).
module tb_hex_display_ctrl;
   import hex_pkg::*;

   localparam int unsigned ND = 8;
   localparam int unsigned VW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          blank_lz = 1'b0;
   logic          load = 1'b0;
   logic          ready, done;
   logic [VW-1:0] value [ND-1:0];
   logic [6:0]    hex   [ND-1:0];
   logic [6:0]    exp   [ND-1:0];
   int            n_total = 0;
   int            n_pass  = 0;

`ifdef HEX_BLINK_EN
   logic [ND-1:0] blink_mask = '0;

   hex_display_ctrl #(.NUM_DIGITS(ND), .VALUE_W(VW), .BLINK_DIV(4)) dut (
      .clk(clk), .rst(rst), .value(value), .blank_lz(blank_lz), .load(load),
      .ready(ready), .done(done), .blink_mask(blink_mask), .Hex_value(hex));
`else
   hex_display_ctrl #(.NUM_DIGITS(ND), .VALUE_W(VW)) dut (
      .clk(clk), .rst(rst), .value(value), .blank_lz(blank_lz), .load(load),
      .ready(ready), .done(done), .Hex_value(hex));
`endif

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   task automatic set_all(input logic [VW-1:0] v);
      for (int i = 0; i < int'(ND); i++) value[i] = v;
   endtask

   // Drive load for exactly one accepting edge.
   task automatic pulse_load(input logic lz);
      @(negedge clk);
      blank_lz = lz;
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic wait_done(output int busy, output bit seen);
      busy = 0;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (ready === 1'b0) busy++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      load = 1'b0;
      set_all('0);
      repeat (3) @(negedge clk);
      n_total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
      for (int i = 0; i < int'(ND); i++) begin
         n_total++;
         if (hex[i] !== SEG_BLANK) $display("FAIL reset_hex[%0d]: got %h expected 7f", i, hex[i]);
         else n_pass++;
      end
      // Load together with reset must not start a conversion.
      load = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      load = 1'b0;
      @(negedge clk);
      n_total++; if (ready !== 1'b1) $display("FAIL reset_wins_load: ready %b expected 1", ready); else n_pass++;
   endtask

   task automatic test_basic();
      int busy;
      bit seen;
      for (int i = 0; i < int'(ND); i++) value[i] = VW'(i);
      pulse_load(1'b0);
      set_all(CODE_MINUS);  // shadow capture must ignore this
      wait_done(busy, seen);
      n_total++; if (seen !== 1'b1) $display("FAIL basic_done_seen: got %b expected 1", seen); else n_pass++;
      n_total++; if (busy !== 9) $display("FAIL basic_busy_cycles: got %0d expected 9", busy); else n_pass++;
      n_total++; if (ready !== 1'b1) $display("FAIL basic_ready_at_done: got %b expected 1", ready); else n_pass++;
      exp = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
      for (int i = 0; i < int'(ND); i++) begin
         n_total++;
         if (hex[i] !== exp[i]) $display("FAIL basic_hex[%0d]: got %h expected %h", i, hex[i], exp[i]);
         else n_pass++;
      end
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", done); else n_pass++;
   endtask

   task automatic test_lz();
      int busy;
      bit seen;
      set_all('0);
      value[2] = 5'h01;
      pulse_load(1'b1);
      wait_done(busy, seen);
      exp = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40};
      for (int i = 0; i < int'(ND); i++) begin
         n_total++;
         if (hex[i] !== exp[i]) $display("FAIL lz_hex[%0d]: got %h expected %h", i, hex[i], exp[i]);
         else n_pass++;
      end
      set_all('0);
      pulse_load(1'b1);
      wait_done(busy, seen);
      exp = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
      for (int i = 0; i < int'(ND); i++) begin
         n_total++;
         if (hex[i] !== exp[i]) $display("FAIL lz_zero_hex[%0d]: got %h expected %h", i, hex[i], exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_special();
      int busy;
      bit seen;
      set_all('0);
      value[7] = CODE_MINUS;
      pulse_load(1'b1);
      wait_done(busy, seen);
      exp = '{7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      for (int i = 0; i < int'(ND); i++) begin
         n_total++;
         if (hex[i] !== exp[i]) $display("FAIL minus_hex[%0d]: got %h expected %h", i, hex[i], exp[i]);
         else n_pass++;
      end
      set_all('0);
      value[7] = CODE_BLANK;
      pulse_load(1'b1);
      wait_done(busy, seen);
      n_total++; if (hex[7] !== 7'h7F) $display("FAIL blank_code_hex7: got %h expected 7f", hex[7]); else n_pass++;
      n_total++; if (hex[0] !== 7'h40) $display("FAIL blank_code_hex0: got %h expected 40", hex[0]); else n_pass++;
   endtask

   task automatic test_drop();
      int dones = 0;
      logic [6:0] snap [ND-1:0];
      snap = '{default: 7'h55};
      for (int i = 0; i < int'(ND); i++) value[i] = VW'(i + 8);
      pulse_load(1'b0);
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (c == 3) begin
            set_all(CODE_MINUS);
            load = 1'b1;
         end else begin
            load = 1'b0;
         end
         if (done === 1'b1) begin
            dones++;
            snap = hex;
         end
      end
      load = 1'b0;
      n_total++; if (dones !== 1) $display("FAIL drop_done_count: got %0d expected 1", dones); else n_pass++;
      exp = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
      for (int i = 0; i < int'(ND); i++) begin
         n_total++;
         if (snap[i] !== exp[i]) $display("FAIL drop_hex[%0d]: got %h expected %h", i, snap[i], exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int busy;
      bit seen;
      set_all(5'h03);
      pulse_load(1'b0);
      wait_done(busy, seen);
      // Reload in the very cycle done is seen: ready is already 1.
      set_all(5'h05);
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      wait_done(busy, seen);
      n_total++; if (seen !== 1'b1) $display("FAIL b2b_done_seen: got %b expected 1", seen); else n_pass++;
      n_total++; if (busy !== 9) $display("FAIL b2b_busy_cycles: got %0d expected 9", busy); else n_pass++;
      n_total++; if (hex[4] !== 7'h12) $display("FAIL b2b_hex4: got %h expected 12", hex[4]); else n_pass++;
   endtask

   task automatic test_reset_abort();
      int dones = 0;
      set_all(5'h08);
      pulse_load(1'b0);
      repeat (3) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_total++; if (ready !== 1'b1) $display("FAIL abort_ready: got %b expected 1", ready); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else n_pass++;
      for (int i = 0; i < int'(ND); i++) begin
         n_total++;
         if (hex[i] !== SEG_BLANK) $display("FAIL abort_hex[%0d]: got %h expected 7f", i, hex[i]);
         else n_pass++;
      end
      rst = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      n_total++; if (dones !== 0) $display("FAIL abort_no_done: got %0d expected 0", dones); else n_pass++;
      n_total++; if (hex[3] !== SEG_BLANK) $display("FAIL abort_hex_stays: got %h expected 7f", hex[3]); else n_pass++;
   endtask

`ifdef HEX_BLINK_EN
   task automatic test_blink();
      logic [6:0] want;
      blink_mask = 8'h01;
      for (int i = 0; i < int'(ND); i++) value[i] = VW'(i);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);        // edge R: counter and phase cleared
      @(negedge clk);
      rst = 1'b0;
      blank_lz = 1'b0;
      load = 1'b1;
      @(posedge clk);        // edge R+1 accepts
      #1 load = 1'b0;
      repeat (9) @(negedge clk);
      for (int k = 10; k < 26; k++) begin
         @(negedge clk);
         want = (((k / 4) % 2) == 1) ? 7'h7F : 7'h40;
         n_total++;
         if (hex[0] !== want) $display("FAIL blink_hex0_k%0d: got %h expected %h", k, hex[0], want);
         else n_pass++;
         n_total++;
         if (hex[1] !== 7'h79) $display("FAIL blink_hex1_k%0d: got %h expected 79", k, hex[1]);
         else n_pass++;
      end
      blink_mask = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_lz();
      test_special();
      test_drop();
      test_back_to_back();
      test_reset_abort();
`ifdef HEX_BLINK_EN
      test_blink();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
